// File: rtl/alu_pkg.sv
// Shared encodings and operand bundle for the ALU compare/count operand stage.
package alu_pkg;

    localparam int unsigned OPND_W = 32;

    typedef enum logic [2:0] {
        CMP_SLT   = 3'b000,
        CMP_SLTU  = 3'b001,
        CMP_SLTI  = 3'b010,
        CMP_SLTIU = 3'b011,
        CMP_CLO   = 3'b100,
        CMP_CLZ   = 3'b101
    } cmp_sel_e;

    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] OP_SLTI     = 6'h0A;
    localparam logic [5:0] OP_SLTIU    = 6'h0B;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;

    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;
    localparam logic [5:0] FN_CLO  = 6'h21;
    localparam logic [5:0] FN_CLZ  = 6'h20;

    typedef struct packed {
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
        cmp_sel_e          sel;
    } operand_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode/funct decode and operand formation for SLT/SLTU/SLTI/SLTIU/CLO/CLZ.
module alu_op_decode
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMM_W  = 16
) (
    input  logic [5:0]        opcode_i,
    input  logic [5:0]        funct_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [IMM_W-1:0]  imm_i,
    output operand_t          ops_o,
    output logic              legal_o
);

    logic [DATA_W-1:0] imm_sext;

    assign imm_sext = {{(DATA_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};

    // Select compare kind and operand B source; unknown encodings flag illegal.
    always_comb begin
        ops_o.a   = rs_data_i;
        ops_o.b   = '0;
        ops_o.sel = CMP_SLT;
        legal_o   = 1'b0;
        unique case (opcode_i)
            OP_SPECIAL: begin
                if (funct_i == FN_SLT) begin
                    ops_o.b   = rt_data_i;
                    ops_o.sel = CMP_SLT;
                    legal_o   = 1'b1;
                end else if (funct_i == FN_SLTU) begin
                    ops_o.b   = rt_data_i;
                    ops_o.sel = CMP_SLTU;
                    legal_o   = 1'b1;
                end
            end
            OP_SLTI: begin
                ops_o.b   = imm_sext;
                ops_o.sel = CMP_SLTI;
                legal_o   = 1'b1;
            end
            // Immediate is sign-extended even here; the compare itself is unsigned.
            OP_SLTIU: begin
                ops_o.b   = imm_sext;
                ops_o.sel = CMP_SLTIU;
                legal_o   = 1'b1;
            end
            OP_SPECIAL2: begin
                if (funct_i == FN_CLO) begin
                    ops_o.sel = CMP_CLO;
                    legal_o   = 1'b1;
                end else if (funct_i == FN_CLZ) begin
                    ops_o.sel = CMP_CLZ;
                    legal_o   = 1'b1;
                end
            end
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand stage ahead of the compare/count unit: decode, then a 2-entry skid
// buffer (main + skid) behind valid/ready. Outputs always come from main.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMM_W  = 16,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [IMM_W-1:0]  imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [2:0]        cmp_sel,
    output logic              illegal,
    output logic [CNT_W-1:0]  illegal_count
);

    operand_t         dec_ops;
    logic             dec_legal;

    operand_t         main_q, main_d;
    operand_t         skid_q, skid_d;
    logic             main_vld_q, main_vld_d;
    logic             skid_vld_q, skid_vld_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             drain;

    alu_op_decode #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_decode (
        .opcode_i  (opcode),
        .funct_i   (funct),
        .rs_data_i (rs_data),
        .rt_data_i (rt_data),
        .imm_i     (imm),
        .ops_o     (dec_ops),
        .legal_o   (dec_legal)
    );

    // Ready depends only on registered state, never on out_ready.
    assign in_ready = !skid_vld_q && !reset;
    assign accept   = in_valid && in_ready;
    assign drain    = main_vld_q && out_ready;

    // Buffer next state. Accept while draining with skid full cannot happen
    // (in_ready=0), so a legal accept lands in main whenever main frees up.
    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        illegal_d  = 1'b0;
        cnt_d      = cnt_q;
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else begin
            if (drain) begin
                if (skid_vld_q) begin
                    main_d     = skid_q;
                    skid_vld_d = 1'b0;
                end else begin
                    main_vld_d = 1'b0;
                end
            end
            if (accept) begin
                if (dec_legal) begin
                    if (!main_vld_q || drain) begin
                        main_d     = dec_ops;
                        main_vld_d = 1'b1;
                    end else begin
                        skid_d     = dec_ops;
                        skid_vld_d = 1'b1;
                    end
                end else begin
                    illegal_d = 1'b1;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            illegal_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            illegal_q  <= illegal_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid     = main_vld_q;
    assign op_a          = main_q.a;
    assign op_b          = main_q.b;
    assign cmp_sel       = main_q.sel;
    assign illegal       = illegal_q;
    assign illegal_count = cnt_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed-vector bench for alu_operand_stage with hand-computed expectations.
module tb_alu_operand_stage;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [15:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [2:0]  cmp_sel;
    logic        illegal;
    logic [7:0]  illegal_count;

    int checks   = 0;
    int failures = 0;

    alu_operand_stage #(
        .DATA_W (32),
        .IMM_W  (16),
        .CNT_W  (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .opcode        (opcode),
        .funct         (funct),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .imm           (imm),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .op_a          (op_a),
        .op_b          (op_b),
        .cmp_sel       (cmp_sel),
        .illegal       (illegal),
        .illegal_count (illegal_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [5:0] opc, input logic [5:0] fn,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] im);
        in_valid = 1'b1;
        opcode   = opc;
        funct    = fn;
        rs_data  = rs;
        rt_data  = rt;
        imm      = im;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_a"}, op_a, a);
        chk({tag, "_b"}, op_b, b);
        chk({tag, "_sel"}, {29'd0, cmp_sel}, {29'd0, sel});
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        opcode = '0; funct = '0; rs_data = '0; rt_data = '0; imm = '0;
        #2 reset = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_op_a", op_a, 32'd0);
        chk("rst_op_b", op_b, 32'd0);
        chk("rst_sel", {29'd0, cmp_sel}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_count", {24'd0, illegal_count}, 32'd0);
        step(); step();
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // SLTI with negative immediate
        offer(6'h0A, 6'h00, 32'h0000_0005, 32'h0, 16'hFFFF);
        step();
        in_valid = 1'b0;
        chk_out("slti", 32'h0000_0005, 32'hFFFF_FFFF, 3'b010);
        step();
        chk("slti_drained", {31'd0, out_valid}, 32'd0);

        // CLZ: operand B forced to zero regardless of rt
        offer(6'h1C, 6'h20, 32'h0000_F000, 32'h1234_5678, 16'h0);
        step();
        in_valid = 1'b0;
        chk_out("clz", 32'h0000_F000, 32'h0, 3'b101);
        step();

        // SLTIU with positive immediate
        offer(6'h0B, 6'h00, 32'hDEAD_BEEF, 32'h0, 16'h7FFF);
        step();
        in_valid = 1'b0;
        chk_out("sltiu", 32'hDEAD_BEEF, 32'h0000_7FFF, 3'b011);
        step();

        // Stall: SLT, SLTU fill main and skid, CLO is refused
        out_ready = 1'b0;
        offer(6'h00, 6'h2A, 32'h0000_0001, 32'h0000_0002, 16'h0);
        step();
        chk_out("stall_slt", 32'h1, 32'h2, 3'b000);
        chk("stall_ready1", {31'd0, in_ready}, 32'd1);
        offer(6'h00, 6'h2B, 32'h0000_0003, 32'h0000_0004, 16'h0);
        step();
        chk("full_ready", {31'd0, in_ready}, 32'd0);
        offer(6'h1C, 6'h21, 32'hFFFF_0000, 32'h0, 16'h0);
        step();
        chk("full_ready_hold", {31'd0, in_ready}, 32'd0);
        chk_out("stall_hold", 32'h1, 32'h2, 3'b000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk_out("drain_sltu", 32'h3, 32'h4, 3'b001);
        chk("ready_after_drain", {31'd0, in_ready}, 32'd1);
        // Drain and accept together with one entry
        offer(6'h1C, 6'h21, 32'hFFFF_0000, 32'h0, 16'h0);
        step();
        in_valid = 1'b0;
        chk_out("drain_clo", 32'hFFFF_0000, 32'h0, 3'b100);
        step();
        chk("empty_after_clo", {31'd0, out_valid}, 32'd0);

        // Illegal opcode: single pulse, counted, not enqueued
        offer(6'h3F, 6'h00, 32'h1, 32'h1, 16'h1);
        step();
        in_valid = 1'b0;
        chk("ill_pulse", {31'd0, illegal}, 32'd1);
        chk("ill_count1", {24'd0, illegal_count}, 32'd1);
        chk("ill_no_enq", {31'd0, out_valid}, 32'd0);
        step();
        chk("ill_pulse_end", {31'd0, illegal}, 32'd0);
        chk("ill_count_hold", {24'd0, illegal_count}, 32'd1);
        // SPECIAL with unsupported funct is illegal too
        offer(6'h00, 6'h20, 32'h1, 32'h1, 16'h1);
        step();
        chk("ill_funct_pulse", {31'd0, illegal}, 32'd1);
        chk("ill_funct_count", {24'd0, illegal_count}, 32'd2);
        offer(6'h3F, 6'h00, 32'h1, 32'h1, 16'h1);
        for (int i = 0; i < 252; i++) step();
        chk("ill_count_254", {24'd0, illegal_count}, 32'd254);
        step();
        chk("ill_count_255", {24'd0, illegal_count}, 32'd255);
        for (int i = 0; i < 4; i++) step();
        in_valid = 1'b0;
        chk("ill_count_sat", {24'd0, illegal_count}, 32'hFF);
        chk("ill_pulse_sat", {31'd0, illegal}, 32'd1);
        step();

        // Flush with both entries occupied
        out_ready = 1'b0;
        offer(6'h00, 6'h2A, 32'hA, 32'hB, 16'h0);
        step();
        offer(6'h00, 6'h2B, 32'hC, 32'hD, 16'h0);
        step();
        chk("pre_flush_full", {31'd0, in_ready}, 32'd0);
        offer(6'h0A, 6'h00, 32'hE, 32'h0, 16'h1);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        step(); step();
        chk("flush_nothing_later", {31'd0, out_valid}, 32'd0);

        // Flush discards an instruction accepted in the same cycle
        offer(6'h00, 6'h2A, 32'h5, 32'h6, 16'h0);
        flush = 1'b1;
        step();
        chk("flush_acc_discard", {31'd0, out_valid}, 32'd0);
        offer(6'h3F, 6'h00, 32'h0, 32'h0, 16'h0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_ill_no_pulse", {31'd0, illegal}, 32'd0);
        chk("flush_count_kept", {24'd0, illegal_count}, 32'hFF);

        // Asynchronous reset in the middle of a stall
        out_ready = 1'b0;
        offer(6'h00, 6'h2A, 32'h11, 32'h22, 16'h0);
        step();
        offer(6'h00, 6'h2B, 32'h33, 32'h44, 16'h0);
        step();
        in_valid = 1'b0;
        chk("pre_areset_valid", {31'd0, out_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("areset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("areset_in_ready", {31'd0, in_ready}, 32'd0);
        chk("areset_op_a", op_a, 32'd0);
        chk("areset_count", {24'd0, illegal_count}, 32'd0);
        step();
        reset     = 1'b0;
        out_ready = 1'b1;
        offer(6'h0A, 6'h00, 32'h0000_0007, 32'h0, 16'h8000);
        step();
        in_valid = 1'b0;
        chk_out("post_areset_slti", 32'h0000_0007, 32'hFFFF_8000, 3'b010);
        step();
        chk("post_areset_drain", {31'd0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Pipeline stage directly upstream of the ALU compare/count unit.
- Decodes MIPS opcode/funct for SLT, SLTU, SLTI, SLTIU, CLO and CLZ into the 3-bit compare select.
- Forms operand A and operand B, including immediate sign-extension.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer, so the compare unit sees stable, registered inputs.

Parameters:
- DATA_W, 32, operand width; only 32 is supported.
- IMM_W, 16, immediate field width.
- CNT_W, 8, width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept this cycle.
- opcode  in  6  instruction bits [31:26].
- funct  in  6  instruction bits [5:0].
- rs_data  in  DATA_W  register-file rs value.
- rt_data  in  DATA_W  register-file rt value.
- imm  in  IMM_W  instruction bits [15:0].
- out_valid  out  1  operands valid to the compare unit.
- out_ready  in  1  compare unit accepts.
- op_a  out  DATA_W  operand A.
- op_b  out  DATA_W  operand B.
- cmp_sel  out  3  000 SLT, 001 SLTU, 010 SLTI, 011 SLTIU, 100 CLO, 101 CLZ.
- illegal  out  1  one-cycle pulse, registered.
- illegal_count  out  CNT_W  saturating count of dropped instructions.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values:
  - out_valid=0, op_a=0, op_b=0, cmp_sel=000, illegal=0, illegal_count=0.
  - Both buffer entries are empty.
  - in_ready is forced 0 while reset is high.
- Decode (combinational, on the input side):
  - opcode 0x00, funct 0x2A -> SLT: A=rs_data, B=rt_data.
  - opcode 0x00, funct 0x2B -> SLTU: A=rs_data, B=rt_data.
  - opcode 0x0A -> SLTI: A=rs_data, B=sign-extended imm.
  - opcode 0x0B -> SLTIU: A=rs_data, B=sign-extended imm (sign-extend, then the downstream compare is unsigned).
  - opcode 0x1C, funct 0x21 -> CLO: A=rs_data, B=0.
  - opcode 0x1C, funct 0x20 -> CLZ: A=rs_data, B=0.
  - Anything else is illegal.
- Accept condition: in_valid && in_ready.
- Legal accepted instruction:
  - If the main entry is empty, or draining this cycle (out_valid && out_ready), it loads the main entry.
  - Otherwise it loads the skid entry.
- Illegal accepted instruction:
  - Not enqueued.
  - illegal=1 the following cycle.
  - illegal_count increments, saturating at all-ones.
- in_ready = !skid_valid && !reset. It is purely a function of registered state and has no combinational path from out_ready.
- Latency: one cycle from accept to out_valid when the buffer is empty.
- Outputs are always driven from the main entry.
- When the main entry drains and the skid entry is full, the skid entry moves to main in the same edge and in_ready rises next cycle.
- Ordering is strictly FIFO; no instruction is lost or duplicated.
- While out_valid=1 && out_ready=0, op_a, op_b and cmp_sel hold stable.
- Full condition: both entries occupied -> in_ready=0.
- Simultaneous drain and accept while full is impossible, because in_ready=0.
- Simultaneous drain and accept with one entry: the new entry goes to main and out_valid stays 1.
- flush:
  - Clears both entries at the clock edge; out_valid=0 next cycle.
  - An instruction accepted in the flush cycle is discarded, including its illegal pulse.
  - illegal_count is not cleared.
- Reset mid-transfer: all state clears immediately (asynchronous); pending entries are lost.

Decomposition:
- Shared package alu_pkg:
  - cmp_sel encodings CMP_SLT..CMP_CLZ.
  - Opcode constants OP_SPECIAL, OP_SLTI, OP_SLTIU, OP_SPECIAL2.
  - Funct constants FN_SLT, FN_SLTU, FN_CLO, FN_CLZ.
  - Operand bundle typedef {a, b, sel}.
- One sub-module, alu_op_decode: purely combinational decode and immediate extension.
- The buffer and handshake stay in the top module.

Test Plan:
- SLTI, rs=0x00000005, imm=0xFFFF, out_ready=1 -> next cycle out_valid=1, op_a=0x00000005, op_b=0xFFFFFFFF, cmp_sel=010.
- CLZ (opcode 0x1C, funct 0x20), rs=0x0000F000 -> op_a=0x0000F000, op_b=0, cmp_sel=101.
- out_ready=0, three back-to-back SLT/SLTU/CLO offered:
  - First two accepted; in_ready=0 on the third.
  - Release out_ready -> outputs in order 000, 001, 100.
  - in_ready returns one cycle after the first drain.
- opcode 0x3F offered -> not enqueued, illegal=1 for exactly one cycle, illegal_count=1; 256 illegals with CNT_W=8 -> count holds at 0xFF.
- Two entries buffered, flush=1 with in_valid=1 -> next cycle out_valid=0, nothing is later output, in_ready=1.
- reset asserted asynchronously mid-stall -> out_valid=0 and in_ready=0 without a clock edge; after deassert, first accept produces normal one-cycle latency.
